mmio_uart_timer: RTL and testbench



---
 rtl/mmio_uart_timer.sv | 215 +++++++++++++++++++++
 tb/tb_mmio_uart_timer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_timer.sv
// mmio_uart_timer: memory-mapped peripheral with a 32-bit compare timer and
// an 8N1 UART transmitter fed from a byte FIFO. Read data is combinational so
// the core's write-back mux can capture it in the same cycle.
module mmio_uart_timer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        m_rnw,
    input  logic        m_sel,
    output logic [31:0] s_data,
    output logic        uart_tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    logic [2:0]  off_s;
    logic        wr_s;
    logic        addr_unused_s;
    logic        st_w1c_s;
    logic        push_req_s;
    logic        push_ok_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic        match_set_s;
    logic        match_next_s;
    logic        ovf_next_s;
    logic [15:0] eff_div_s;

    logic [31:0] timer_r;
    logic [31:0] cmp_r;
    logic [15:0] baud_r;
    logic [2:0]  ctrl_r;
    logic        match_r;
    logic        ovf_r;
    logic        irq_r;
    logic [7:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    tx_state_t   state_r;
    logic [7:0]  shift_r;
    logic [15:0] cnt_r;
    logic [15:0] div_r;
    logic [2:0]  bit_r;
    logic        tx_r;

    assign off_s         = m_addr[4:2];
    assign wr_s          = m_sel & ~m_rnw;
    assign addr_unused_s = ^{m_addr[31:5], m_addr[1:0]};
    assign st_w1c_s      = wr_s && (off_s == 3'd1);
    assign push_req_s    = wr_s && (off_s == 3'd0);

    // The extra pointer bit distinguishes full from empty when the indices meet.
    assign empty_s = (wptr_r == rptr_r);
    assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign pop_s   = (state_r == S_IDLE) && ctrl_r[1] && !empty_s;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok_s = push_req_s && (!full_s || pop_s);

    assign eff_div_s    = (baud_r == 16'd0) ? 16'd1 : baud_r;
    assign match_set_s  = ctrl_r[0] && (timer_r == cmp_r);
    assign match_next_s = match_set_s || (match_r && !(st_w1c_s && m_data[3]));
    assign ovf_next_s   = (push_req_s && full_s && !pop_s) ||
                          (ovf_r && !(st_w1c_s && m_data[4]));

    assign uart_tx = tx_r;
    assign irq     = irq_r;

    // Combinational read mux; reads never change state.
    always_comb begin
        s_data = 32'd0;
        if (m_sel && m_rnw) begin
            case (off_s)
                3'd1:    s_data = {27'd0, ovf_r, match_r, (state_r != S_IDLE), empty_s, full_s};
                3'd2:    s_data = {16'd0, baud_r};
                3'd3:    s_data = timer_r;
                3'd4:    s_data = cmp_r;
                3'd5:    s_data = {29'd0, ctrl_r};
                default: s_data = 32'd0;
            endcase
        end else begin
            s_data = 32'd0;
        end
    end

    // Free-running timer; a bus write takes priority over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= 32'd0;
        end else if (wr_s && (off_s == 3'd3)) begin
            timer_r <= m_data;
        end else if (ctrl_r[0]) begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Plain read/write configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_r  <= 32'hFFFF_FFFF;
            baud_r <= BAUD_RST;
            ctrl_r <= 3'd0;
        end else if (wr_s) begin
            if (off_s == 3'd4) cmp_r  <= m_data;
            if (off_s == 3'd2) baud_r <= m_data[15:0];
            if (off_s == 3'd5) ctrl_r <= m_data[2:0];
        end
    end

    // Sticky status flags (set beats clear) and the interrupt, which trails match by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_r <= 1'b0;
            ovf_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            match_r <= match_next_s;
            ovf_r   <= ovf_next_s;
            irq_r   <= match_r & ctrl_r[2];
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wptr_r[AW-1:0]] <= m_data[7:0];
        end
    end

    // FIFO pointers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + 1'b1;
            if (pop_s)     rptr_r <= rptr_r + 1'b1;
        end
    end

    // 8N1 transmitter; uart_tx is loaded with the level of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            shift_r <= 8'd0;
            cnt_r   <= 16'd0;
            div_r   <= 16'd1;
            bit_r   <= 3'd0;
            tx_r    <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r <= fifo_mem_r[rptr_r[AW-1:0]];
                        cnt_r   <= eff_div_s;
                        div_r   <= eff_div_s;
                        bit_r   <= 3'd0;
                        tx_r    <= 1'b0;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_r == 16'd1) begin
                        cnt_r   <= div_r;
                        tx_r    <= shift_r[0];
                        state_r <= S_DATA;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_r == 16'd1) begin
                        cnt_r <= div_r;
                        if (bit_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= S_STOP;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_r == 16'd1) begin
                        tx_r    <= 1'b1;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_timer.sv
// Testbench for mmio_uart_timer: directed bus sequences with literal checks,
// a register/frame-level reference model compared every cycle, and a simple
// UART receiver that decodes the serial line back into bytes.
module tb_mmio_uart_timer;

    localparam logic [31:0] A_TX   = 32'h00;
    localparam logic [31:0] A_ST   = 32'h04;
    localparam logic [31:0] A_BAUD = 32'h08;
    localparam logic [31:0] A_TMR  = 32'h0C;
    localparam logic [31:0] A_CMP  = 32'h10;
    localparam logic [31:0] A_CTRL = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_rnw;
    logic        m_sel;
    logic [31:0] s_data;
    logic        uart_tx;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_prints  = 0;

    mmio_uart_timer #(.FIFO_DEPTH(8), .BAUD_RST(16'd434)) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_data(m_data), .m_rnw(m_rnw),
        .m_sel(m_sel), .s_data(s_data), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (register and frame level) ----------------
    logic [31:0] md_timer, md_cmp;
    logic [15:0] md_baud;
    logic [2:0]  md_ctrl;
    logic        md_match, md_ovf, md_irq, md_tx;
    logic [7:0]  md_fifo[$];
    int          md_edge = 0;
    bit          md_active;
    int          md_fstart, md_fdiv;
    logic [9:0]  md_fbits;

    function automatic logic md_busy();
        return md_active && ((md_edge - md_fstart) < 10 * md_fdiv);
    endfunction

    task automatic model_reset();
        md_timer = 32'd0; md_cmp = 32'hFFFF_FFFF; md_baud = 16'd434; md_ctrl = 3'd0;
        md_match = 1'b0; md_ovf = 1'b0; md_irq = 1'b0; md_tx = 1'b1;
        md_fifo.delete(); md_active = 1'b0; md_fstart = 0; md_fdiv = 1; md_fbits = 10'h3FF;
    endtask

    task automatic model_step();
        logic w, mset, pop, push, full, idle_prev, nm, no;
        logic [2:0] off;
        logic [7:0] b;
        int k;
        md_edge++;
        if (rst) begin
            model_reset();
        end else begin
            w    = m_sel && !m_rnw;
            off  = m_addr[4:2];
            mset = md_ctrl[0] && (md_timer == md_cmp);
            idle_prev = !md_active || ((md_edge - 1 - md_fstart) >= 10 * md_fdiv);
            pop  = md_ctrl[1] && (md_fifo.size() > 0) && idle_prev;
            push = w && (off == 3'd0);
            full = (md_fifo.size() == 8);
            nm = mset || (md_match && !(w && off == 3'd1 && m_data[3]));
            no = (push && full && !pop) || (md_ovf && !(w && off == 3'd1 && m_data[4]));
            md_irq   = md_match && md_ctrl[2];
            md_match = nm;
            md_ovf   = no;
            if (pop) begin
                b = md_fifo.pop_front();
                md_fbits  = {1'b1, b, 1'b0};
                md_fstart = md_edge;
                md_fdiv   = (md_baud == 16'd0) ? 1 : int'({16'd0, md_baud});
                md_active = 1'b1;
            end
            if (push && (!full || pop)) md_fifo.push_back(m_data[7:0]);
            if (w && off == 3'd3) md_timer = m_data;
            else if (md_ctrl[0]) md_timer = md_timer + 32'd1;
            if (w && off == 3'd4) md_cmp  = m_data;
            if (w && off == 3'd2) md_baud = m_data[15:0];
            if (w && off == 3'd5) md_ctrl = m_data[2:0];
        end
        if (md_busy()) begin
            k = (md_edge - md_fstart) / md_fdiv;
            md_tx = md_fbits[4'(k)];
        end else begin
            md_tx = 1'b1;
        end
    endtask

    function automatic logic [31:0] md_read(logic sel, logic rnw, logic [31:0] a);
        if (!sel || !rnw) return 32'd0;
        case (a[4:2])
            3'd1: return {27'd0, md_ovf, md_match, md_busy(), (md_fifo.size() == 0), (md_fifo.size() == 8)};
            3'd2: return {16'd0, md_baud};
            3'd3: return md_timer;
            3'd4: return md_cmp;
            3'd5: return {29'd0, md_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            e = md_read(m_sel, m_rnw, m_addr);
            vectors++;
            if (s_data !== e || uart_tx !== md_tx || irq !== md_irq) begin
                miscompares++;
                if (cyc_prints < 20) begin
                    cyc_prints++;
                    $display("FAIL cycle_model @%0t: s_data=%h need %h, uart_tx=%b need %b, irq=%b need %b",
                             $time, s_data, e, uart_tx, md_tx, irq, md_irq);
                end
            end
        end
    end

    // ---------------- UART receiver ----------------
    int         rx_div = 4;
    logic [7:0] rx_q[$];
    logic [7:0] rx_b;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                repeat (rx_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (rx_div) @(negedge clk);
                    rx_b[i] = uart_tx;
                end
                repeat (rx_div) @(negedge clk);
                if (uart_tx === 1'b1) rx_q.push_back(rx_b);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        m_sel = 1'b1; m_rnw = 1'b0; m_addr = a; m_data = d;
        tick();
        m_sel = 1'b0; m_rnw = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        m_sel = 1'b1; m_rnw = 1'b1; m_addr = a;
        #1;
        chk(nm, s_data, exp);
        @(negedge clk);
        #1;
        m_sel = 1'b0;
    endtask

    function automatic logic [7:0] rx_at(int i);
        return (rx_q.size() > i) ? rx_q[i] : 8'h00;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] eb;
        logic [7:0] e8;
        rst = 1'b1; m_sel = 1'b0; m_rnw = 1'b1; m_addr = 32'd0; m_data = 32'd0;
        #1;
        repeat (3) tick();
        rst = 1'b0;

        // 1: reset state
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        m_sel = 1'b0; m_rnw = 1'b1; m_addr = A_CTRL; #1;
        chk("sel0_read", s_data, 32'd0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_baud", A_BAUD, 32'd434);
        rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rst_status", A_ST, 32'h02);
        rd("rst_timer", A_TMR, 32'd0);
        rd("read_txdata", A_TX, 32'd0);
        rd("read_undef", 32'h18, 32'd0);

        // 2: single frame of 0xA5 at divisor 4
        wr(A_BAUD, 32'd4);
        wr(A_CTRL, 32'h2);
        wr(A_TX, 32'hA5);
        chk("t2_idle_after_push", {31'd0, uart_tx}, 32'd1);
        tick();
        chk("t2_start_low", {31'd0, uart_tx}, 32'd0);
        eb = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) begin
            tick(); tick();
            chk($sformatf("t2_bit%0d", j), {31'd0, uart_tx}, {31'd0, eb[j]});
            if (j < 9) begin
                tick(); tick();
            end else begin
                tick();
            end
        end
        rd("t2_busy_last", A_ST, 32'h06);
        tick();
        rd("t2_idle", A_ST, 32'h02);
        tick(); tick();
        chk("t2_rx_count", 32'(rx_q.size()), 32'd1);
        chk("t2_rx_byte", {24'd0, rx_at(0)}, 32'hA5);

        // 3: fill past depth, overflow, drain
        wr(A_CTRL, 32'h0);
        rx_q.delete();
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + 32'(i));
        rd("t3_full_ovf", A_ST, 32'h11);
        wr(A_CTRL, 32'h2);
        repeat (345) tick();
        rd("t3_drained", A_ST, 32'h12);
        chk("t3_rx_count", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            e8 = 8'h10 + 8'(i);
            chk($sformatf("t3_rx%0d", i), {24'd0, rx_at(i)}, {24'd0, e8});
        end
        wr(A_ST, 32'h10);
        rd("t3_ovf_cleared", A_ST, 32'h02);

        // 4: compare match, irq latency, set-beats-clear
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h5);
        repeat (5) tick();
        rd("t4_no_match_yet", A_ST, 32'h02);
        chk("t4_irq_pre", {31'd0, irq}, 32'd0);
        tick();
        rd("t4_match", A_ST, 32'h0A);
        chk("t4_irq_same", {31'd0, irq}, 32'd0);
        tick();
        chk("t4_irq_set", {31'd0, irq}, 32'd1);
        wr(A_ST, 32'h08);
        rd("t4_match_w1c", A_ST, 32'h02);
        chk("t4_irq_lag", {31'd0, irq}, 32'd1);
        tick();
        chk("t4_irq_clear", {31'd0, irq}, 32'd0);
        wr(A_TMR, 32'd3);
        tick(); tick();
        wr(A_ST, 32'h08);
        rd("t4_set_wins", A_ST, 32'h0A);
        rd("t4_timer", A_TMR, 32'd6);

        // 5: wrap and write-on-wrap
        wr(A_TMR, 32'hFFFF_FFFE);
        rd("t5_fffffffe", A_TMR, 32'hFFFF_FFFE);
        tick(); rd("t5_ffffffff", A_TMR, 32'hFFFF_FFFF);
        tick(); rd("t5_wrap0", A_TMR, 32'd0);
        tick(); rd("t5_one", A_TMR, 32'd1);
        wr(A_TMR, 32'hFFFF_FFFE);
        tick(); rd("t5_pre_wrap", A_TMR, 32'hFFFF_FFFF);
        wr(A_TMR, 32'h100);
        rd("t5_write_wins", A_TMR, 32'h100);
        tick(); rd("t5_after", A_TMR, 32'h101);

        // 6: reset mid-frame
        wr(A_CTRL, 32'h2);
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'h81);
        repeat (6) tick();
        chk("t6_mid_bit_low", {31'd0, uart_tx}, 32'd0);
        #2 rst = 1'b1;
        #1 chk("t6_async_high", {31'd0, uart_tx}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        rd("t6_fifo_empty", A_ST, 32'h02);
        rd("t6_baud_rst", A_BAUD, 32'd434);
        repeat (50) tick();
        rx_q.delete();
        rx_div = 3;
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'h2);
        wr(A_TX, 32'hC3);
        repeat (35) tick();
        chk("t6_rx_count", 32'(rx_q.size()), 32'd1);
        chk("t6_rx_byte", {24'd0, rx_at(0)}, 32'hC3);
        rd("t6_idle", A_ST, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
